param_ir_alu_datapath: RTL and testbench
========================================

// Module: param_ir_alu_datapath
// PURPOSE
//  Parametrised successor to the fixed 16-bit IR/MAR/ALU datapath. Latches one instruction
//  from data_bus, decodes it into exported fields, reads a small register file, executes
//  on an 8-function ALU and writes back. Sits between the control unit (valid/ready) and memory (MAR).
// PARAMETERS
//  DW    16  datapath, IR and MAR width (>= 12)
//  NREG   4  register-file depth, power of 2; RAW = $clog2(NREG)
//  OPW    4  opcode width; IMW = DW-OPW-2*RAW-3 (5 at defaults), must be >= 1
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     synchronous reset, active-high
//  data_bus     in   DW    instruction word
//  instr_valid  in   1     data_bus holds an instruction
//  instr_ready  out  1     block accepts an instruction this cycle
//  opcode       out  OPW   IR[DW-1 -: OPW]
//  rd           out  RAW   IR field under opcode
//  rs           out  RAW   IR field under rd
//  funct        out  3     IR field under rs
//  imm          out  IMW   IR[IMW-1:0]
//  mar          out  DW    memory address register
//  result       out  DW    last ALU result (registered)
//  flags        out  4     {Z,N,C,V}
//  done         out  1     1-cycle pulse: instruction retired
//  err          out  1     1-cycle pulse: illegal opcode retired
//  dbg_addr     in   RAW   register-file debug read address
//  dbg_data     out  DW    regfile[dbg_addr], combinational
// BEHAVIOUR
//  - Reset: state IDLE; IR, mar, result, flags, all regfile entries = 0; done = err = 0;
//    instr_ready = 0 while rst is high. Reset in any state aborts; no writeback occurs.
//  - FSM IDLE->DECODE->EXEC->WB->IDLE. instr_ready = (state==IDLE) & ~rst.
//  - IDLE: on instr_valid & instr_ready, IR <= data_bus -> DECODE. instr_valid in other states is ignored.
//  - DECODE: A <= reg[rd], B <= (op==ALU_I) ? sext(imm) : reg[rs].
//  - EXEC: ALU_R(0)/ALU_I(1): result <= alu(A,B,funct), flags updated.
//    LDMAR(2): mar <= reg[rs]; result and flags held. Other opcodes: nothing is written.
//  - WB: ALU ops write reg[rd] <= result. done=1 for every legal op; err=1 (done=0) for an illegal op.
//  - Latency: accept at edge 0, done/err high in cycle 3; next accept at edge 4 (4 cycles/instr).
//  - funct: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 PASS B.
//    Shift amount = B[$clog2(DW)-1:0]; logical shifts zero-fill.
//  - Flags: Z = (res==0), N = res[DW-1]. ADD: C = carry out, V = signed overflow.
//    SUB: computed as A+~B+1, C = carry out (1 = no borrow), V = signed overflow.
//    All other functs: C = V = 0.
//  - All arithmetic is mod 2^DW. The IR holds its value until the next accept.
//  - dbg_data shows the pre-write value during the WB cycle and the new value after the edge.
// STRUCTURE
//  - package datapath_pkg: opcode constants OP_ALU_R/OP_ALU_I/OP_LDMAR, funct constants
//    F_ADD..F_PASS, state enum {IDLE,DECODE,EXEC,WB}, flag bit indices.
//  - sub-module dp_alu (combinational; A, B, funct -> res, flags); FSM, IR, MAR and regfile stay in the top.
// TESTING  (DW=16, NREG=4; layout op[15:12] rd[11:10] rs[9:8] funct[7:5] imm[4:0])
//  1 Reset, then 0x1405 (r1 += 5) -> instr_ready drops; done in cycle 3; r1=0x0005; flags=0000.
//  2 0x0520 (r1 = r1 - r1) -> result=0x0000, flags Z=1 C=1 N=0 V=0.
//  3 0x181F (r2 += -1) -> r2=0xFFFF, N=1, C=0; then 0x1801 (r2 += 1) -> r2=0x0000, Z=1, C=1.
//  4 0x1C07 (r3=7), then 0x2300 (LDMAR rs=r3) -> mar=0x0007; flags and r0..r3 unchanged; done pulses.
//  5 0xF155 (illegal) -> err pulses in cycle 3, done stays 0, no reg/flag change; ready again next cycle.
//  6 Hold instr_valid=1 with 0x1405 through busy cycles -> only one accept per 4 cycles;
//    assert rst during EXEC -> r1 stays 0, all outputs at reset values on the next edge.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared constants for the parametrised IR/ALU datapath: opcodes, ALU functions,
// controller states and flag bit positions.
package datapath_pkg;

    localparam int OP_ALU_R = 0;
    localparam int OP_ALU_I = 1;
    localparam int OP_LDMAR = 2;

    localparam logic [2:0] F_ADD  = 3'b000;
    localparam logic [2:0] F_SUB  = 3'b001;
    localparam logic [2:0] F_AND  = 3'b010;
    localparam logic [2:0] F_OR   = 3'b011;
    localparam logic [2:0] F_XOR  = 3'b100;
    localparam logic [2:0] F_SLL  = 3'b101;
    localparam logic [2:0] F_SRL  = 3'b110;
    localparam logic [2:0] F_PASS = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_e;

    // Positions inside the 4-bit {Z,N,C,V} flag vector.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/param_ir_alu_datapath_alu.sv
// Combinational 8-function ALU producing a DW-bit result and {Z,N,C,V} flags.
module dp_alu
    import datapath_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [2:0]    funct_i,
    output logic [DW-1:0] res_o,
    output logic [3:0]    flags_o
);

    localparam int SHW = $clog2(DW);

    logic [DW-1:0] b_op;
    logic          cin;
    logic [DW:0]   sum;
    logic          c;
    logic          v;

    // SUB is A + ~B + 1, so the carry/overflow logic is shared with ADD.
    assign b_op = (funct_i == F_SUB) ? ~b_i : b_i;
    assign cin  = (funct_i == F_SUB);
    assign sum  = {1'b0, a_i} + {1'b0, b_op} + {{DW{1'b0}}, cin};

    always_comb begin
        res_o = '0;
        c     = 1'b0;
        v     = 1'b0;
        case (funct_i)
            F_ADD, F_SUB: begin
                res_o = sum[DW-1:0];
                c     = sum[DW];
                v     = (a_i[DW-1] == b_op[DW-1]) && (sum[DW-1] != a_i[DW-1]);
            end
            F_AND:   res_o = a_i & b_i;
            F_OR:    res_o = a_i | b_i;
            F_XOR:   res_o = a_i ^ b_i;
            F_SLL:   res_o = a_i << b_i[SHW-1:0];
            F_SRL:   res_o = a_i >> b_i[SHW-1:0];
            F_PASS:  res_o = b_i;
            default: res_o = '0;
        endcase
    end

    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_Z] = (res_o == '0);
        flags_o[FLAG_N] = res_o[DW-1];
        flags_o[FLAG_C] = c;
        flags_o[FLAG_V] = v;
    end

endmodule

// File: rtl/param_ir_alu_datapath.sv
// Four-cycle IR/MAR/ALU datapath: accept, decode + regfile read, execute, write back.
// Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready.
module param_ir_alu_datapath
    import datapath_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 4,
    parameter int OPW  = 4,
    localparam int RAW = $clog2(NREG),
    localparam int IMW = DW - OPW - 2*RAW - 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   data_bus,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [OPW-1:0]  opcode,
    output logic [RAW-1:0]  rd,
    output logic [RAW-1:0]  rs,
    output logic [2:0]      funct,
    output logic [IMW-1:0]  imm,
    output logic [DW-1:0]   mar,
    output logic [DW-1:0]   result,
    output logic [3:0]      flags,
    output logic            done,
    output logic            err,
    input  logic [RAW-1:0]  dbg_addr,
    output logic [DW-1:0]   dbg_data,
    output state_e          dbg_state
);

    state_e        state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] mar_q, mar_d;
    logic [DW-1:0] res_q, res_d;
    logic [3:0]    flags_q, flags_d;
    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];

    logic [DW-1:0] alu_res;
    logic [3:0]    alu_flags;
    logic          is_alu_r, is_alu_i, is_ldmar, is_alu;

    assign opcode = ir_q[DW-1 -: OPW];
    assign rd     = ir_q[DW-OPW-1 -: RAW];
    assign rs     = ir_q[DW-OPW-RAW-1 -: RAW];
    assign funct  = ir_q[IMW+2 -: 3];
    assign imm    = ir_q[IMW-1:0];

    assign is_alu_r = (opcode == OPW'(OP_ALU_R));
    assign is_alu_i = (opcode == OPW'(OP_ALU_I));
    assign is_ldmar = (opcode == OPW'(OP_LDMAR));
    assign is_alu   = is_alu_r | is_alu_i;

    assign mar       = mar_q;
    assign result    = res_q;
    assign flags     = flags_q;
    assign dbg_data  = rf_q[dbg_addr];
    assign dbg_state = state_q;

    dp_alu #(.DW(DW)) u_alu (
        .a_i     (a_q),
        .b_i     (b_q),
        .funct_i (funct),
        .res_o   (alu_res),
        .flags_o (alu_flags)
    );

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        mar_d       = mar_q;
        res_d       = res_q;
        flags_d     = flags_q;
        rf_d        = rf_q;
        done        = 1'b0;
        err         = 1'b0;
        instr_ready = (state_q == IDLE) && !rst;
        case (state_q)
            IDLE: begin
                if (instr_valid && instr_ready) begin
                    ir_d    = data_bus;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d     = rf_q[rd];
                b_d     = is_alu_i ? {{(DW-IMW){imm[IMW-1]}}, imm} : rf_q[rs];
                state_d = EXEC;
            end
            EXEC: begin
                if (is_alu) begin
                    res_d   = alu_res;
                    flags_d = alu_flags;
                end else if (is_ldmar) begin
                    mar_d = rf_q[rs];
                end
                state_d = WB;
            end
            WB: begin
                if (is_alu) begin
                    rf_d[rd] = res_q;
                end
                // Pulses are masked during reset so an aborted WB never reports retirement.
                done    = (is_alu || is_ldmar) && !rst;
                err     = !(is_alu || is_ldmar) && !rst;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mar_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mar_q   <= mar_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            rf_q    <= rf_d;
        end
    end

endmodule

// File: tb/tb_param_ir_alu_datapath.sv
// Directed-vector bench: the driver pushes hand-computed expectations, the monitor
// pops one on every done/err pulse and compares.
module tb_param_ir_alu_datapath;
    import datapath_pkg::*;

    typedef struct packed {
        logic        is_err;
        logic [15:0] res;
        logic [3:0]  fl;
        logic [15:0] mar_v;
        logic [1:0]  rd_v;
        logic [15:0] old_v;
        logic [15:0] new_v;
        logic [31:0] cyc_done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_bus;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  opcode;
    logic [1:0]  rd, rs;
    logic [2:0]  funct;
    logic [4:0]  imm;
    logic [15:0] mar, result, dbg_data;
    logic [3:0]  flags;
    logic        done, err;
    logic [1:0]  dbg_addr;
    state_e      dbg_state;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 0;
    int          acc_cnt = 0;

    param_ir_alu_datapath #(.DW(16), .NREG(4), .OPW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_bus    (data_bus),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .rd          (rd),
        .rs          (rs),
        .funct       (funct),
        .imm         (imm),
        .mar         (mar),
        .result      (result),
        .flags       (flags),
        .done        (done),
        .err         (err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .dbg_state   (dbg_state)
    );

    // Clock / reset-independent bookkeeping
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (instr_valid && instr_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic is_err, input logic [15:0] res, input logic [3:0] fl,
                            input logic [15:0] mar_v, input logic [1:0] rd_v,
                            input logic [15:0] old_v, input logic [15:0] new_v,
                            input logic [31:0] cyc_done);
        exp_t e;
        e.is_err   = is_err;
        e.res      = res;
        e.fl       = fl;
        e.mar_v    = mar_v;
        e.rd_v     = rd_v;
        e.old_v    = old_v;
        e.new_v    = new_v;
        e.cyc_done = cyc_done;
        exp_q.push_back(e);
    endtask

    // Driver: wait (bounded) for ready on a negedge, present one instruction for one edge.
    task automatic issue(input logic [15:0] instr, input logic is_err, input logic [15:0] res,
                         input logic [3:0] fl, input logic [15:0] mar_v, input logic [1:0] rd_v,
                         input logic [15:0] old_v, input logic [15:0] new_v);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 32'd1);
        data_bus    = instr;
        instr_valid = 1'b1;
        push_exp(is_err, res, fl, mar_v, rd_v, old_v, new_v, cyc + 3);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // Monitor
    initial begin
        exp_t e;
        dbg_addr = 2'd0;
        forever begin
            @(negedge clk);
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 32'(done | err), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("retire_cycle", cyc, e.cyc_done);
                    chk("done", 32'(done), 32'(!e.is_err));
                    chk("err", 32'(err), 32'(e.is_err));
                    chk("result", 32'(result), 32'(e.res));
                    chk("flags", 32'(flags), 32'(e.fl));
                    chk("mar", 32'(mar), 32'(e.mar_v));
                    dbg_addr = e.rd_v;
                    #1;
                    chk("dbg_pre_write", 32'(dbg_data), 32'(e.old_v));
                    @(posedge clk);
                    #1;
                    chk("dbg_post_write", 32'(dbg_data), 32'(e.new_v));
                    chk("pulse_cleared", 32'(done | err), 32'd0);
                    chk("ready_after", 32'(instr_ready), 32'd1);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        int acc0;
        logic [31:0] c0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        data_bus    = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_mar", 32'(mar), 32'd0);
        chk("rst_pulses", 32'(done | err), 32'd0);
        chk("rst_r0", 32'(dbg_data), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_out_of_rst", 32'(instr_ready), 32'd1);

        //    instr    err  res      fl    mar      rd  old      new
        issue(16'h1405, 0, 16'h0005, 4'h0, 16'h0000, 1, 16'h0000, 16'h0005);
        chk("ready_drops", 32'(instr_ready), 32'd0);
        issue(16'h0520, 0, 16'h0000, 4'hA, 16'h0000, 1, 16'h0005, 16'h0000);
        issue(16'h181F, 0, 16'hFFFF, 4'h4, 16'h0000, 2, 16'h0000, 16'hFFFF);
        issue(16'h1801, 0, 16'h0000, 4'hA, 16'h0000, 2, 16'hFFFF, 16'h0000);
        issue(16'h1C07, 0, 16'h0007, 4'h0, 16'h0000, 3, 16'h0000, 16'h0007);
        issue(16'h2300, 0, 16'h0007, 4'h0, 16'h0007, 0, 16'h0000, 16'h0000);
        issue(16'hF155, 1, 16'h0007, 4'h0, 16'h0007, 0, 16'h0000, 16'h0000);
        chk("dec_opcode", 32'(opcode), 32'hF);
        chk("dec_rd", 32'(rd), 32'd0);
        chk("dec_rs", 32'(rs), 32'd1);
        chk("dec_funct", 32'(funct), 32'd2);
        chk("dec_imm", 32'(imm), 32'h15);
        issue(16'h1C3F, 0, 16'h0008, 4'h0, 16'h0007, 3, 16'h0007, 16'h0008);
        issue(16'h1CA2, 0, 16'h0020, 4'h0, 16'h0007, 3, 16'h0008, 16'h0020);
        issue(16'h14FF, 0, 16'hFFFF, 4'h4, 16'h0007, 1, 16'h0000, 16'hFFFF);
        issue(16'h14C1, 0, 16'h7FFF, 4'h0, 16'h0007, 1, 16'hFFFF, 16'h7FFF);
        issue(16'h1401, 0, 16'h8000, 4'h5, 16'h0007, 1, 16'h7FFF, 16'h8000);
        issue(16'h0640, 0, 16'h0000, 4'h8, 16'h0007, 1, 16'h8000, 16'h0000);
        issue(16'h0760, 0, 16'h0020, 4'h0, 16'h0007, 1, 16'h0000, 16'h0020);

        // Hold instr_valid through busy cycles: accepts at edges 0, 4, 8 only.
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        c0   = cyc;
        acc0 = acc_cnt;
        data_bus    = 16'h1405;
        instr_valid = 1'b1;
        push_exp(0, 16'h0025, 4'h0, 16'h0007, 1, 16'h0020, 16'h0025, c0 + 3);
        push_exp(0, 16'h002A, 4'h0, 16'h0007, 1, 16'h0025, 16'h002A, c0 + 7);
        push_exp(0, 16'h002F, 4'h0, 16'h0007, 1, 16'h002A, 16'h002F, c0 + 11);
        repeat (12) @(negedge clk);
        instr_valid = 1'b0;
        chk("held_accept_count", 32'(acc_cnt - acc0), 32'd3);

        // Reset during EXEC aborts the instruction with no writeback.
        n = 0;
        @(negedge clk);
        while ((!instr_ready || exp_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        data_bus    = 16'h1405;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("in_exec", 32'(dbg_state), 32'(EXEC));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_state", 32'(dbg_state), 32'(IDLE));
        chk("abort_ready", 32'(instr_ready), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_flags", 32'(flags), 32'd0);
        chk("abort_mar", 32'(mar), 32'd0);
        chk("abort_opcode", 32'(opcode), 32'd0);
        chk("abort_pulses", 32'(done | err), 32'd0);
        chk("abort_r1", 32'(dbg_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
